// File: rtl/dm_s2mm_sequencer.sv
// ============================================================================
// Module      : dm_s2mm_sequencer
// Description : Multi-descriptor command sequencer for the datamover S2MM
//               channel. Queues host descriptors, issues datamover commands
//               with rolling 4-bit tags (up to C_MAX_OUTSTANDING in flight),
//               gates the accelerator stream with a per-packet credit count,
//               and checks returned status for completion/error/irq reporting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: DM_SEQ_WATCHDOG_EN
//   Defined     : watchdog counter; on C_TIMEOUT idle cycles with commands in
//                 flight it sets err_sticky_o[2], raises irq_o and blocks any
//                 further command issue until reset.
//   Not defined : no counter, err_sticky_o[2] tied low, issue never blocked.
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, aresetn_i            clock, asynchronous active-low reset
//   desc_*                      descriptor push into the FIFO (addr, btt)
//   m_axis_cmd_*                datamover command channel (out)
//   s_axis_sts_*                datamover status channel (in, always ready)
//   s_axis_* / m_axis_*         stream in from accelerator / out to datamover
//   done_valid_o/tag_o/err_o    one-cycle completion report
//   err_sticky_o                [0] status error, [1] tag mismatch, [2] timeout
//   irq_clr_i, irq_o            level interrupt and its clear
//   outstanding_o, queue_level_o  live occupancy counters
// ============================================================================
`default_nettype none

module dm_s2mm_sequencer #(
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_QUEUE_LOG2      = 3,
    parameter int C_MAX_OUTSTANDING = 4,
    parameter int C_TIMEOUT         = 1024
) (
    input  logic                           clk_i,
    input  logic                           aresetn_i,
    // descriptor push
    input  logic                           desc_valid_i,
    output logic                           desc_ready_o,
    input  logic [C_ADDR_WIDTH-1:0]        desc_addr_i,
    input  logic [22:0]                    desc_btt_i,
    // datamover command
    output logic                           m_axis_cmd_tvalid_o,
    input  logic                           m_axis_cmd_tready_i,
    output logic [C_ADDR_WIDTH+39:0]       m_axis_cmd_tdata_o,
    // datamover status
    input  logic                           s_axis_sts_tvalid_i,
    output logic                           s_axis_sts_tready_o,
    input  logic [7:0]                     s_axis_sts_tdata_i,
    // stream from accelerator
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic                           s_axis_tlast_i,
    input  logic                           s_axis_tvalid_i,
    output logic                           s_axis_tready_o,
    // stream to datamover
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic                           m_axis_tlast_o,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    // completion / error reporting
    output logic                           done_valid_o,
    output logic [3:0]                     done_tag_o,
    output logic                           done_err_o,
    output logic [2:0]                     err_sticky_o,
    input  logic                           irq_clr_i,
    output logic                           irq_o,
    output logic [3:0]                     outstanding_o,
    output logic [C_QUEUE_LOG2:0]          queue_level_o
);

    localparam int                    DEPTH    = 2**C_QUEUE_LOG2;
    localparam logic [C_QUEUE_LOG2:0] FULL_LVL = {1'b1, {C_QUEUE_LOG2{1'b0}}};
    localparam logic [3:0]            MAX_OUT  = 4'(C_MAX_OUTSTANDING);

    // Elaboration-time parameter sanity check.
    if (C_MAX_OUTSTANDING < 1 || C_MAX_OUTSTANDING > 15 || C_TIMEOUT < 1 ||
        C_QUEUE_LOG2 < 1) begin : g_bad_param
        $error("dm_s2mm_sequencer: illegal parameter value");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [22:0]             btt_mem_q  [DEPTH];
    logic [C_QUEUE_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_QUEUE_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_QUEUE_LOG2:0]   level_q,  level_d;

    logic [3:0]              tag_q,    tag_d;
    logic [3:0]              credits_q, credits_d;
    logic [3:0]              outstanding_q, outstanding_d;

    // Expected-tag queue: one entry per command in flight, popped by status.
    logic [3:0]              tq_mem_q [16];
    logic [3:0]              tq_wr_q, tq_rd_q;

    logic                    done_valid_q;
    logic [3:0]              done_tag_q;
    logic                    done_err_q;
    logic [2:0]              err_sticky_q, err_sticky_d;
    logic                    irq_q, irq_d;

    // ------------------------------------------------------------------
    // Handshakes and gating
    // ------------------------------------------------------------------
    logic w_push, w_pop, w_cmd_valid, w_cmd_hs;
    logic w_pass, w_beat, w_last_beat;
    logic w_sts_hs, w_sts_err, w_tag_mis, w_out_nz;
    logic w_wd_fire, w_wd_block;

    assign desc_ready_o = (level_q != FULL_LVL);
    assign w_push       = desc_valid_i && desc_ready_o;

    assign w_cmd_valid  = (level_q != '0) && (outstanding_q < MAX_OUT) && !w_wd_block;
    assign w_cmd_hs     = w_cmd_valid && m_axis_cmd_tready_i;
    assign w_pop        = w_cmd_hs;

    // Command word built from the FIFO head; forced to zero while not valid
    // so the unreset storage never shows on the port.
    assign m_axis_cmd_tvalid_o = w_cmd_valid;
    assign m_axis_cmd_tdata_o  = w_cmd_valid ?
        {4'b0000, tag_q, addr_mem_q[rd_ptr_q],
         1'b0,          // DRR
         1'b1,          // EOF
         6'b000000,
         1'b1,          // INCR
         btt_mem_q[rd_ptr_q]} : '0;

    // Stream gate: a beat may only move while at least one packet is owed.
    assign w_pass          = (credits_q != 4'd0);
    assign m_axis_tvalid_o = s_axis_tvalid_i && w_pass;
    assign s_axis_tready_o = m_axis_tready_i && w_pass;
    assign m_axis_tdata_o  = s_axis_tdata_i;
    assign m_axis_tlast_o  = s_axis_tlast_i;
    assign w_beat          = s_axis_tvalid_i && s_axis_tready_o;
    assign w_last_beat     = w_beat && s_axis_tlast_i;

    // Status channel is always accepted.
    assign s_axis_sts_tready_o = 1'b1;
    assign w_sts_hs  = s_axis_sts_tvalid_i;
    assign w_sts_err = (|s_axis_sts_tdata_i[6:4]) || !s_axis_sts_tdata_i[7];
    assign w_out_nz  = (outstanding_q != 4'd0);
    // A status with nothing in flight is treated as a tag mismatch.
    assign w_tag_mis = w_sts_hs &&
                       (!w_out_nz || (s_axis_sts_tdata_i[3:0] != tq_mem_q[tq_rd_q]));

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef DM_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(C_TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_trip_q;
    logic            w_wd_run;

    // Counts idle cycles with work in flight; any progress restarts it.
    assign w_wd_run   = w_out_nz && !w_beat && !w_sts_hs && !wd_trip_q;
    assign w_wd_fire  = w_wd_run && (wd_cnt_q == WD_W'(C_TIMEOUT - 1));
    assign w_wd_block = wd_trip_q;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            if (w_wd_run) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end else begin
                wd_cnt_q <= '0;
            end
            if (w_wd_fire) begin
                wd_trip_q <= 1'b1;
            end
        end
    end
`else
    assign w_wd_fire  = 1'b0;
    assign w_wd_block = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        tag_d         = tag_q;
        credits_d     = credits_q;
        outstanding_d = outstanding_q;
        err_sticky_d  = err_sticky_q;
        irq_d         = irq_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_QUEUE_LOG2'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_QUEUE_LOG2'(1);
            tag_d    = tag_q + 4'd1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + (C_QUEUE_LOG2+1)'(1);
            2'b01:   level_d = level_q - (C_QUEUE_LOG2+1)'(1);
            default: level_d = level_q;
        endcase

        // A packet end and a new command in the same cycle cancel out.
        case ({w_cmd_hs, w_last_beat})
            2'b10:   credits_d = credits_q + 4'd1;
            2'b01:   credits_d = credits_q - 4'd1;
            default: credits_d = credits_q;
        endcase

        case ({w_cmd_hs, w_sts_hs && w_out_nz})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (w_sts_hs && w_sts_err) begin
            err_sticky_d[0] = 1'b1;
        end
        if (w_tag_mis) begin
            err_sticky_d[1] = 1'b1;
        end
        if (w_wd_fire) begin
            err_sticky_d[2] = 1'b1;
        end

        // Set has priority over clear.
        if (done_valid_q || w_wd_fire) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Descriptor storage needs no reset: it is only read while occupied.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            addr_mem_q[wr_ptr_q] <= desc_addr_i;
            btt_mem_q[wr_ptr_q]  <= desc_btt_i;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            tag_q         <= '0;
            credits_q     <= '0;
            outstanding_q <= '0;
            tq_wr_q       <= '0;
            tq_rd_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                tq_mem_q[i] <= '0;
            end
            done_valid_q  <= 1'b0;
            done_tag_q    <= '0;
            done_err_q    <= 1'b0;
            err_sticky_q  <= '0;
            irq_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            tag_q         <= tag_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            if (w_cmd_hs) begin
                tq_mem_q[tq_wr_q] <= tag_q;
                tq_wr_q           <= tq_wr_q + 4'd1;
            end
            if (w_sts_hs && w_out_nz) begin
                tq_rd_q <= tq_rd_q + 4'd1;
            end
            done_valid_q  <= w_sts_hs;
            if (w_sts_hs) begin
                done_tag_q <= s_axis_sts_tdata_i[3:0];
                done_err_q <= w_sts_err;
            end
            err_sticky_q  <= err_sticky_d;
            irq_q         <= irq_d;
        end
    end

    assign done_valid_o  = done_valid_q;
    assign done_tag_o    = done_tag_q;
    assign done_err_o    = done_err_q;
    assign err_sticky_o  = err_sticky_q;
    assign irq_o         = irq_q;
    assign outstanding_o = outstanding_q;
    assign queue_level_o = level_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_s2mm_sequencer.sv
// ============================================================================
// Module      : tb_dm_s2mm_sequencer
// Description : Directed self-checking bench for dm_s2mm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_s2mm_sequencer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_addr;
    logic [22:0] desc_btt;
    logic        cmd_tvalid, cmd_tready;
    logic [71:0] cmd_tdata;
    logic        sts_tvalid, sts_tready;
    logic [7:0]  sts_tdata;
    logic [63:0] s_tdata, m_tdata;
    logic        s_tlast, s_tvalid, s_tready;
    logic        m_tlast, m_tvalid, m_tready;
    logic        done_valid, done_err;
    logic [3:0]  done_tag;
    logic [2:0]  err_sticky;
    logic        irq_clr, irq;
    logic [3:0]  outstanding;
    logic [3:0]  queue_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_s2mm_sequencer #(
        .C_ADDR_WIDTH      (32),
        .C_AXIS_DATA_WIDTH (64),
        .C_QUEUE_LOG2      (3),
        .C_MAX_OUTSTANDING (4),
        .C_TIMEOUT         (16)
    ) dut (
        .clk_i               (clk),
        .aresetn_i           (aresetn),
        .desc_valid_i        (desc_valid),
        .desc_ready_o        (desc_ready),
        .desc_addr_i         (desc_addr),
        .desc_btt_i          (desc_btt),
        .m_axis_cmd_tvalid_o (cmd_tvalid),
        .m_axis_cmd_tready_i (cmd_tready),
        .m_axis_cmd_tdata_o  (cmd_tdata),
        .s_axis_sts_tvalid_i (sts_tvalid),
        .s_axis_sts_tready_o (sts_tready),
        .s_axis_sts_tdata_i  (sts_tdata),
        .s_axis_tdata_i      (s_tdata),
        .s_axis_tlast_i      (s_tlast),
        .s_axis_tvalid_i     (s_tvalid),
        .s_axis_tready_o     (s_tready),
        .m_axis_tdata_o      (m_tdata),
        .m_axis_tlast_o      (m_tlast),
        .m_axis_tvalid_o     (m_tvalid),
        .m_axis_tready_i     (m_tready),
        .done_valid_o        (done_valid),
        .done_tag_o          (done_tag),
        .done_err_o          (done_err),
        .err_sticky_o        (err_sticky),
        .irq_clr_i           (irq_clr),
        .irq_o               (irq),
        .outstanding_o       (outstanding),
        .queue_level_o       (queue_level)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle descriptor push (no checking).
    task automatic push_desc(input logic [31:0] a, input logic [22:0] b);
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_btt   = b;
        tick();
        desc_valid = 1'b0;
    endtask

    // One-cycle status return (no checking).
    task automatic send_sts(input logic [7:0] s);
        sts_tvalid = 1'b1;
        sts_tdata  = s;
        tick();
        sts_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({desc_ready, sts_tready, cmd_tvalid, m_tvalid, s_tready, done_valid, done_err, irq} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=%b",
                     {desc_ready, sts_tready, cmd_tvalid, m_tvalid, s_tready, done_valid, done_err, irq}, 8'b1100_0000);
        end
        checks++;
        if (cmd_tdata !== 72'h0) begin
            errors++; $display("FAIL reset_cmd_tdata got=%h exp=0", cmd_tdata);
        end
        checks++;
        if ({err_sticky, outstanding, queue_level, done_tag} !== 15'h0) begin
            errors++;
            $display("FAIL reset_counters err=%b out=%0d lvl=%0d tag=%0d exp all 0", err_sticky, outstanding, queue_level, done_tag);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_cmd_issue();
        logic [71:0] exp_cmd;
        cmd_tready = 1'b0;
        push_desc(32'h1000, 23'd64);
        push_desc(32'h2000, 23'd64);
        push_desc(32'h3000, 23'd64);
        checks++;
        if (queue_level !== 4'd3 || cmd_tvalid !== 1'b1) begin
            errors++; $display("FAIL issue_level got lvl=%0d valid=%b exp lvl=3 valid=1", queue_level, cmd_tvalid);
        end
        exp_cmd = {4'h0, 4'h0, 32'h0000_1000, 1'b0, 1'b1, 6'h00, 1'b1, 23'd64};
        checks++;
        if (cmd_tdata !== exp_cmd) begin
            errors++; $display("FAIL issue_first_word got=%h exp=%h", cmd_tdata, exp_cmd);
        end
        checks++;
        if (cmd_tdata[63:32] !== 32'h1000 || cmd_tdata[23] !== 1'b1 || cmd_tdata[30] !== 1'b1) begin
            errors++; $display("FAIL issue_fields got addr=%h b23=%b b30=%b exp 1000/1/1", cmd_tdata[63:32], cmd_tdata[23], cmd_tdata[30]);
        end
        cmd_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_tvalid !== 1'b1 || cmd_tdata[67:64] !== 4'(i) || cmd_tdata[63:32] !== 32'(32'h1000 * (i + 1))) begin
                errors++;
                $display("FAIL issue_cmd%0d got valid=%b tag=%0d addr=%h exp 1/%0d/%h",
                         i, cmd_tvalid, cmd_tdata[67:64], cmd_tdata[63:32], i, 32'h1000 * (i + 1));
            end
            tick();
        end
        cmd_tready = 1'b0;
        checks++;
        if (cmd_tvalid !== 1'b0 || outstanding !== 4'd3 || queue_level !== 4'd0) begin
            errors++; $display("FAIL issue_after got valid=%b out=%0d lvl=%0d exp 0/3/0", cmd_tvalid, outstanding, queue_level);
        end
    endtask

    task automatic test_status_ok();
        for (int i = 0; i < 3; i++) begin
            send_sts(8'h80 | 8'(i));
            checks++;
            if (done_valid !== 1'b1 || done_tag !== 4'(i) || done_err !== 1'b0 || outstanding !== 4'(2 - i)) begin
                errors++;
                $display("FAIL sts_ok%0d got dv=%b tag=%0d err=%b out=%0d exp 1/%0d/0/%0d",
                         i, done_valid, done_tag, done_err, outstanding, i, 2 - i);
            end
        end
        tick();
        checks++;
        if (irq !== 1'b1 || err_sticky !== 3'b000 || done_valid !== 1'b0) begin
            errors++; $display("FAIL sts_ok_irq got irq=%b err=%b dv=%b exp 1/000/0", irq, err_sticky, done_valid);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL sts_ok_irq_clr got=%b exp=0", irq);
        end
    endtask

    // Three credits are owed from the first test; drain them with 1-beat packets.
    task automatic test_passthrough();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 64'hA5A5_0000_0000_0000 + 64'(i);
            #1;
            checks++;
            if (m_tvalid !== 1'b1 || s_tready !== 1'b1 || m_tdata !== 64'hA5A5_0000_0000_0000 + 64'(i) || m_tlast !== 1'b1) begin
                errors++;
                $display("FAIL pass_beat%0d got mv=%b sr=%b data=%h last=%b", i, m_tvalid, s_tready, m_tdata, m_tlast);
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            errors++; $display("FAIL pass_closed got mv=%b sr=%b exp 0/0", m_tvalid, s_tready);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_stream_gate();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = 64'hDEAD_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
                errors++; $display("FAIL gate_closed%0d got sr=%b mv=%b exp 0/0", i, s_tready, m_tvalid);
            end
            tick();
        end
        cmd_tready = 1'b1;
        push_desc(32'h4000, 23'd512);
        checks++;
        if (s_tready !== 1'b0 || cmd_tvalid !== 1'b1 || cmd_tdata[67:64] !== 4'd3) begin
            errors++; $display("FAIL gate_precmd got sr=%b cv=%b tag=%0d exp 0/1/3", s_tready, cmd_tvalid, cmd_tdata[67:64]);
        end
        tick();
        cmd_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_tdata = 64'hDEAD_0000_0000_0000 + 64'(i);
            s_tlast = (i == 7);
            #1;
            checks++;
            if (m_tvalid !== 1'b1 || s_tready !== 1'b1 || m_tdata !== 64'hDEAD_0000_0000_0000 + 64'(i) || m_tlast !== (i == 7)) begin
                errors++;
                $display("FAIL gate_beat%0d got mv=%b sr=%b data=%h last=%b", i, m_tvalid, s_tready, m_tdata, m_tlast);
            end
            tick();
        end
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++; $display("FAIL gate_reclosed got sr=%b mv=%b exp 0/0", s_tready, m_tvalid);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        send_sts(8'h83);
        checks++;
        if (done_valid !== 1'b1 || done_tag !== 4'd3 || outstanding !== 4'd0) begin
            errors++; $display("FAIL gate_sts got dv=%b tag=%0d out=%0d exp 1/3/0", done_valid, done_tag, outstanding);
        end
    endtask

    task automatic test_max_outstanding();
        cmd_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_desc(32'h5000 + 32'(i * 256), 23'd128);
        end
        tick();
        tick();
        checks++;
        if (outstanding !== 4'd4 || cmd_tvalid !== 1'b0 || queue_level !== 4'd2) begin
            errors++; $display("FAIL max_cap got out=%0d cv=%b lvl=%0d exp 4/0/2", outstanding, cmd_tvalid, queue_level);
        end
        // Deliver one packet, then its status, as a datamover would.
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        send_sts(8'h84);
        checks++;
        if (done_valid !== 1'b1 || done_tag !== 4'd4 || done_err !== 1'b0 || outstanding !== 4'd3) begin
            errors++; $display("FAIL max_sts got dv=%b tag=%0d err=%b out=%0d exp 1/4/0/3", done_valid, done_tag, done_err, outstanding);
        end
        checks++;
        if (cmd_tvalid !== 1'b1 || cmd_tdata[67:64] !== 4'd8 || cmd_tdata[63:32] !== 32'h5400) begin
            errors++; $display("FAIL max_fifth got cv=%b tag=%0d addr=%h exp 1/8/5400", cmd_tvalid, cmd_tdata[67:64], cmd_tdata[63:32]);
        end
        tick();
        checks++;
        if (outstanding !== 4'd4 || queue_level !== 4'd1 || cmd_tvalid !== 1'b0) begin
            errors++; $display("FAIL max_refill got out=%0d lvl=%0d cv=%b exp 4/1/0", outstanding, queue_level, cmd_tvalid);
        end
        cmd_tready = 1'b0;
    endtask

    task automatic test_status_error();
        // Tag 5 is expected; 0xC1 carries tag 1 and a slave-error bit.
        send_sts(8'hC1);
        checks++;
        if (done_valid !== 1'b1 || done_err !== 1'b1 || done_tag !== 4'd1 || err_sticky !== 3'b011 || outstanding !== 4'd3) begin
            errors++;
            $display("FAIL err_sts got dv=%b err=%b tag=%0d sticky=%b out=%0d exp 1/1/1/011/3",
                     done_valid, done_err, done_tag, err_sticky, outstanding);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL err_irq got=%b exp=1", irq);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0 || err_sticky !== 3'b011) begin
            errors++; $display("FAIL err_clr got irq=%b sticky=%b exp 0/011", irq, err_sticky);
        end
        // Clear held while a completion is reported: set must win.
        send_sts(8'h86);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b1 || err_sticky !== 3'b011) begin
            errors++; $display("FAIL err_set_wins got irq=%b sticky=%b exp 1/011", irq, err_sticky);
        end
    endtask

    task automatic test_fifo_full_reset();
        cmd_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_desc(32'h9000 + 32'(i), 23'd8);
        end
        checks++;
        if (desc_ready !== 1'b0 || queue_level !== 4'd8) begin
            errors++; $display("FAIL full_level got rdy=%b lvl=%0d exp 0/8", desc_ready, queue_level);
        end
        push_desc(32'hBAD0, 23'd8);
        checks++;
        if (queue_level !== 4'd8) begin
            errors++; $display("FAIL full_refuse got lvl=%0d exp 8", queue_level);
        end
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if (desc_ready !== 1'b1 || queue_level !== 4'd0 || outstanding !== 4'd0 || err_sticky !== 3'b000 ||
            irq !== 1'b0 || cmd_tvalid !== 1'b0 || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b lvl=%0d out=%0d sticky=%b irq=%b cv=%b dv=%b",
                     desc_ready, queue_level, outstanding, err_sticky, irq, cmd_tvalid, done_valid);
        end
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_credits got sr=%b mv=%b exp 0/0", s_tready, m_tvalid);
        end
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_watchdog();
        m_tready   = 1'b0;
        s_tvalid   = 1'b1;
        s_tlast    = 1'b0;
        cmd_tready = 1'b1;
        push_desc(32'hA000, 23'd32);
        tick();
        cmd_tready = 1'b0;
        push_desc(32'hB000, 23'd32);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checks++;
`ifdef DM_SEQ_WATCHDOG_EN
        if (err_sticky !== 3'b100 || irq !== 1'b1 || cmd_tvalid !== 1'b0 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL watchdog got sticky=%b irq=%b cv=%b out=%0d exp 100/1/0/1", err_sticky, irq, cmd_tvalid, outstanding);
        end
`else
        if (err_sticky !== 3'b000 || irq !== 1'b0 || cmd_tvalid !== 1'b1 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL no_watchdog got sticky=%b irq=%b cv=%b out=%0d exp 000/0/1/1", err_sticky, irq, cmd_tvalid, outstanding);
        end
`endif
        s_tvalid = 1'b0;
    endtask

    initial begin
        aresetn    = 1'b0;
        desc_valid = 1'b0;
        desc_addr  = '0;
        desc_btt   = '0;
        cmd_tready = 1'b0;
        sts_tvalid = 1'b0;
        sts_tdata  = '0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b0;
        irq_clr    = 1'b0;

        test_reset();
        test_cmd_issue();
        test_status_ok();
        test_passthrough();
        test_stream_gate();
        test_max_outstanding();
        test_status_error();
        test_fifo_full_reset();
        test_watchdog();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
